// File: rtl/cpu_ctl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// opcode constants and IR field positions.
package cpu_ctl_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    T0      = 3'd1,
    T1      = 3'd2,
    T2      = 3'd3,
    T3      = 3'd4,
    T4      = 3'd5,
    T5      = 3'd6,
    S_HALT  = 3'd7
  } state_e;

  localparam logic [4:0] OP_ALU_LO = 5'b00011;
  localparam logic [4:0] OP_ALU_HI = 5'b01011;
  localparam logic [4:0] OP_NOP    = 5'b11010;
  localparam logic [4:0] OP_HALT   = 5'b11011;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  // Register-register ALU opcodes occupy one contiguous range.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, 3-step register-register ALU
// execute T3-T5, memory-ready wait with timeout abort, stop/halt handling.
module control_sequencer
  import cpu_ctl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15  // must be >= 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Mem_Ready,
  input  logic        Stop,
  output logic        PC_Out,
  output logic        MAR_In,
  output logic        IncPC,
  output logic        Z_In,
  output logic        ZLO_Out,
  output logic        PC_In,
  output logic        Read,
  output logic        MDR_In,
  output logic        MDR_Out,
  output logic        IR_In,
  output logic        Y_In,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_In,
  output logic        R_Out,
  output logic [4:0]  CONTROL,
  output logic        Run,
  output logic        Illegal,
  output logic        Mem_Err
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          halted_q, halted_d;
  logic          illegal_q, illegal_d;
  logic          mem_err_q, mem_err_d;

  logic [4:0] opcode;
  logic       unused_ir_fields;

  assign opcode = IR[OPC_MSB:OPC_LSB];
  // Ra/Rb/Rc are decoded inside the Datapath from Gra/Grb/Grc.
  assign unused_ir_fields = ^IR[RA_MSB:0];

  // State, wait counter, halt flag and pulse registers.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q   <= S_RESET;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic and Moore strobe decode.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    halted_d  = halted_q;
    illegal_d = 1'b0;
    mem_err_d = 1'b0;

    PC_Out  = 1'b0;
    MAR_In  = 1'b0;
    IncPC   = 1'b0;
    Z_In    = 1'b0;
    ZLO_Out = 1'b0;
    PC_In   = 1'b0;
    Read    = 1'b0;
    MDR_In  = 1'b0;
    MDR_Out = 1'b0;
    IR_In   = 1'b0;
    Y_In    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    R_In    = 1'b0;
    R_Out   = 1'b0;
    CONTROL = '0;
    Run     = 1'b0;

    unique case (state_q)
      S_RESET: state_d = T0;

      T0: begin
        Run     = 1'b1;
        PC_Out  = 1'b1;
        MAR_In  = 1'b1;
        IncPC   = 1'b1;
        Z_In    = 1'b1;
        wait_d  = '0;
        state_d = T1;
      end

      T1: begin
        Run     = 1'b1;
        ZLO_Out = 1'b1;
        PC_In   = 1'b1;
        Read    = 1'b1;
        MDR_In  = 1'b1;
        if (Mem_Ready) begin
          wait_d  = '0;
          state_d = T2;
        end else if (wait_q >= WAIT_LAST) begin
          wait_d    = '0;
          mem_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      T2: begin
        Run     = 1'b1;
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
        state_d = T3;
      end

      T3: begin
        Run = 1'b1;
        if (is_alu_op(opcode)) begin
          Grb     = 1'b1;
          R_Out   = 1'b1;
          Y_In    = 1'b1;
          state_d = T4;
        end else if (opcode == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          illegal_d = (opcode != OP_NOP);
          state_d   = Stop ? S_HALT : T0;
        end
      end

      T4: begin
        Run     = 1'b1;
        Grc     = 1'b1;
        R_Out   = 1'b1;
        Z_In    = 1'b1;
        CONTROL = opcode;
        state_d = T5;
      end

      T5: begin
        Run     = 1'b1;
        ZLO_Out = 1'b1;
        Gra     = 1'b1;
        R_In    = 1'b1;
        state_d = Stop ? S_HALT : T0;
      end

      S_HALT: begin
        if (!halted_q && !Stop) state_d = T0;
      end

      default: state_d = S_RESET;
    endcase
  end

  assign Illegal = illegal_q;
  assign Mem_Err = mem_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: cycle vector table plus
// hand-written timeout, halt and asynchronous clear sequences.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = '0;
  logic        Mem_Ready = 1'b0;
  logic        Stop = 1'b0;
  logic PC_Out, MAR_In, IncPC, Z_In, ZLO_Out, PC_In, Read, MDR_In;
  logic MDR_Out, IR_In, Y_In, Gra, Grb, Grc, R_In, R_Out;
  logic [4:0] CONTROL;
  logic Run, Illegal, Mem_Err;

  control_sequencer #(.MEM_TIMEOUT(15)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_Ready(Mem_Ready), .Stop(Stop),
    .PC_Out(PC_Out), .MAR_In(MAR_In), .IncPC(IncPC), .Z_In(Z_In),
    .ZLO_Out(ZLO_Out), .PC_In(PC_In), .Read(Read), .MDR_In(MDR_In),
    .MDR_Out(MDR_Out), .IR_In(IR_In), .Y_In(Y_In), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .R_In(R_In), .R_Out(R_Out), .CONTROL(CONTROL), .Run(Run),
    .Illegal(Illegal), .Mem_Err(Mem_Err)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, read, mdr_in;
    logic mdr_out, ir_in, y_in, gra, grb, grc, r_in, r_out;
    logic [4:0] control;
    logic run, illegal, mem_err;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    logic        rdy;
    logic        stop;
    int          p;
    logic [4:0]  ctl;
    logic        ill;
    logic        merr;
  } vec_t;

  localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3A = 4,
                 P_T3N = 5, P_T4 = 6, P_T5 = 7;

  localparam logic [31:0] I_ALU  = 32'h4A92_0000;  // op 01001
  localparam logic [31:0] I_ALUL = 32'h1800_0000;  // op 00011
  localparam logic [31:0] I_ALUH = 32'h5800_0000;  // op 01011
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;
  localparam logic [31:0] I_BAD1 = 32'hF800_0000;  // op 11111
  localparam logic [31:0] I_BAD2 = 32'h6000_0000;  // op 01100
  localparam logic [31:0] I_BAD3 = 32'h1000_0000;  // op 00010

  obs_t act;
  assign act = {PC_Out, MAR_In, IncPC, Z_In, ZLO_Out, PC_In, Read, MDR_In,
                MDR_Out, IR_In, Y_In, Gra, Grb, Grc, R_In, R_Out,
                CONTROL, Run, Illegal, Mem_Err};

  obs_t exp_q[$];
  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  function automatic obs_t ph(input int p, input logic [4:0] ctl,
                              input logic ill, input logic merr);
    obs_t o = '0;
    case (p)
      P_T0:  begin o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1; end
      P_T1:  begin o.zlo_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1; end
      P_T2:  begin o.mdr_out = 1; o.ir_in = 1; end
      P_T3A: begin o.grb = 1; o.r_out = 1; o.y_in = 1; end
      P_T4:  begin o.grc = 1; o.r_out = 1; o.z_in = 1; end
      P_T5:  begin o.zlo_out = 1; o.gra = 1; o.r_in = 1; end
      default: ;
    endcase
    o.run     = (p != P_IDLE);
    o.control = ctl;
    o.illegal = ill;
    o.mem_err = merr;
    return o;
  endfunction

  task automatic add(input logic [31:0] ir, input logic rdy, input logic stop,
                     input int p, input logic [4:0] ctl, input logic ill,
                     input logic merr);
    vec_t v;
    v.ir = ir; v.rdy = rdy; v.stop = stop; v.p = p;
    v.ctl = ctl; v.ill = ill; v.merr = merr;
    tbl.push_back(v);
  endtask

  task automatic check_now(input int id);
    obs_t e;
    e = exp_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL step%0d got=%h want=%h", id, act, e);
    end
  endtask

  // Called at posedge+1: drive inputs, compare at the following negedge.
  task automatic step(input logic [31:0] ir, input logic rdy, input logic stop,
                      input obs_t e, input int id);
    IR = ir; Mem_Ready = rdy; Stop = stop;
    exp_q.push_back(e);
    @(negedge Clock);
    check_now(id);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // S_RESET, ALU op 01001 with zero wait
    add(I_ALU, 1, 0, P_IDLE, 0, 0, 0);
    add(I_ALU, 1, 0, P_T0,   0, 0, 0);
    add(I_ALU, 1, 0, P_T1,   0, 0, 0);
    add(I_ALU, 1, 0, P_T2,   0, 0, 0);
    add(I_ALU, 1, 0, P_T3A,  0, 0, 0);
    add(I_ALU, 1, 0, P_T4,   5'b01001, 0, 0);
    add(I_ALU, 1, 0, P_T5,   0, 0, 0);
    // three wait cycles in T1
    add(I_ALU, 0, 0, P_T0,   0, 0, 0);
    add(I_ALU, 0, 0, P_T1,   0, 0, 0);
    add(I_ALU, 0, 0, P_T1,   0, 0, 0);
    add(I_ALU, 0, 0, P_T1,   0, 0, 0);
    add(I_ALU, 1, 0, P_T1,   0, 0, 0);
    add(I_ALU, 1, 0, P_T2,   0, 0, 0);
    add(I_ALU, 1, 0, P_T3A,  0, 0, 0);
    add(I_ALU, 1, 0, P_T4,   5'b01001, 0, 0);
    add(I_ALU, 1, 0, P_T5,   0, 0, 0);
    // illegal opcode 11111
    add(I_BAD1, 1, 0, P_T0,  0, 0, 0);
    add(I_BAD1, 1, 0, P_T1,  0, 0, 0);
    add(I_BAD1, 1, 0, P_T2,  0, 0, 0);
    add(I_BAD1, 1, 0, P_T3N, 0, 0, 0);
    // Stop raised in T4 does not cut the instruction short
    add(I_ALU, 1, 0, P_T0,   0, 1, 0);
    add(I_ALU, 1, 0, P_T1,   0, 0, 0);
    add(I_ALU, 1, 0, P_T2,   0, 0, 0);
    add(I_ALU, 1, 0, P_T3A,  0, 0, 0);
    add(I_ALU, 1, 1, P_T4,   5'b01001, 0, 0);
    add(I_ALU, 1, 1, P_T5,   0, 0, 0);
    add(I_ALU, 1, 0, P_IDLE, 0, 0, 0);
    // NOP: four cycles
    add(I_NOP, 1, 0, P_T0,   0, 0, 0);
    add(I_NOP, 1, 0, P_T1,   0, 0, 0);
    add(I_NOP, 1, 0, P_T2,   0, 0, 0);
    add(I_NOP, 1, 0, P_T3N,  0, 0, 0);
    // ALU range edges
    add(I_ALUL, 1, 0, P_T0,  0, 0, 0);
    add(I_ALUL, 1, 0, P_T1,  0, 0, 0);
    add(I_ALUL, 1, 0, P_T2,  0, 0, 0);
    add(I_ALUL, 1, 0, P_T3A, 0, 0, 0);
    add(I_ALUL, 1, 0, P_T4,  5'b00011, 0, 0);
    add(I_ALUL, 1, 0, P_T5,  0, 0, 0);
    add(I_ALUH, 1, 0, P_T0,  0, 0, 0);
    add(I_ALUH, 1, 0, P_T1,  0, 0, 0);
    add(I_ALUH, 1, 0, P_T2,  0, 0, 0);
    add(I_ALUH, 1, 0, P_T3A, 0, 0, 0);
    add(I_ALUH, 1, 0, P_T4,  5'b01011, 0, 0);
    add(I_ALUH, 1, 0, P_T5,  0, 0, 0);
    // just outside the ALU range on both sides
    add(I_BAD2, 1, 0, P_T0,  0, 0, 0);
    add(I_BAD2, 1, 0, P_T1,  0, 0, 0);
    add(I_BAD2, 1, 0, P_T2,  0, 0, 0);
    add(I_BAD2, 1, 0, P_T3N, 0, 0, 0);
    add(I_BAD3, 1, 0, P_T0,  0, 1, 0);
    add(I_BAD3, 1, 0, P_T1,  0, 0, 0);
    add(I_BAD3, 1, 0, P_T2,  0, 0, 0);
    add(I_BAD3, 1, 0, P_T3N, 0, 0, 0);
    add(I_ALU,  1, 0, P_T0,  0, 1, 0);

    // Reset state while Clear is held
    #2;
    exp_q.push_back(ph(P_IDLE, 0, 0, 0));
    check_now(900);
    @(posedge Clock); #1;
    step(I_ALU, 1, 0, ph(P_IDLE, 0, 0, 0), 901);
    Clear = 1'b0;

    foreach (tbl[i])
      step(tbl[i].ir, tbl[i].rdy, tbl[i].stop,
           ph(tbl[i].p, tbl[i].ctl, tbl[i].ill, tbl[i].merr), i);

    // Mem_Ready stuck low: exactly 15 cycles in T1, then Mem_Err and S_HALT
    for (int i = 0; i < 15; i++)
      step(I_ALU, 0, 0, ph(P_T1, 0, 0, 0), 100 + i);
    step(I_ALU, 0, 1, ph(P_IDLE, 0, 0, 1), 120);
    step(I_ALU, 1, 0, ph(P_IDLE, 0, 0, 0), 121);
    step(I_HALT, 1, 0, ph(P_T0, 0, 0, 0), 122);

    // HALT opcode: parked until Clear regardless of Stop
    step(I_HALT, 1, 0, ph(P_T1, 0, 0, 0), 200);
    step(I_HALT, 1, 0, ph(P_T2, 0, 0, 0), 201);
    step(I_HALT, 1, 0, ph(P_T3N, 0, 0, 0), 202);
    for (int i = 0; i < 6; i++)
      step(I_HALT, 1, logic'(i % 2), ph(P_IDLE, 0, 0, 0), 210 + i);

    // Clear exits halt, then an asynchronous Clear mid-T4
    Clear = 1'b1;
    step(I_ALU, 1, 0, ph(P_IDLE, 0, 0, 0), 300);
    Clear = 1'b0;
    step(I_ALU, 1, 0, ph(P_IDLE, 0, 0, 0), 301);
    step(I_ALU, 1, 0, ph(P_T0, 0, 0, 0), 302);
    step(I_ALU, 1, 0, ph(P_T1, 0, 0, 0), 303);
    step(I_ALU, 1, 0, ph(P_T2, 0, 0, 0), 304);
    step(I_ALU, 1, 0, ph(P_T3A, 0, 0, 0), 305);
    #1;
    exp_q.push_back(ph(P_T4, 5'b01001, 0, 0));
    check_now(306);
    #1 Clear = 1'b1;
    #1;
    exp_q.push_back(ph(P_IDLE, 0, 0, 0));
    check_now(307);
    @(posedge Clock); #1;
    Clear = 1'b0;
    step(I_ALU, 1, 0, ph(P_IDLE, 0, 0, 0), 308);
    step(I_ALU, 1, 0, ph(P_T0, 0, 0, 0), 309);
    step(I_ALU, 1, 0, ph(P_T1, 0, 0, 0), 310);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
